// File: rtl/vx_tex_req_arb_if.sv
// Bundles the source-side request handshake and the texture-unit-side port.
// The arbiter takes the slave view; whatever drives it takes the master view.
interface vx_tex_req_arb_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 256,
  parameter int TAGW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) ();

  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS-1:0][DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]            req_ready;
  logic                           out_valid;
  logic [DATAW-1:0]               out_data;
  logic [TAGW-1:0]                out_tag;
  logic                           out_ready;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_tag
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/vx_tex_req_arb.sv
// Round-robin merge of NUM_REQS texture request sources into one texture-unit
// port through a 2-entry {tag, data} queue. Entry 0 is always the head, so
// out_* come straight from flops and keep their last value when empty.
module vx_tex_req_arb #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 256,
  parameter int TAGW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  vx_tex_req_arb_if.slave     bus,
  output logic [31:0]         perf_stalls
);

  localparam int unsigned NR = NUM_REQS;

  logic [TAGW-1:0]  ptr_q,    ptr_d;
  logic [1:0]       count_q,  count_d;
  logic [TAGW-1:0]  tag_q[2], tag_d[2];
  logic [DATAW-1:0] data_q[2], data_d[2];
  logic [31:0]      stalls_q, stalls_d;

  logic                win_found;
  logic [TAGW-1:0]     win_idx;
  int unsigned         scan;
  logic [NUM_REQS-1:0] ready;
  logic                can_push;
  logic                push;
  logic                pop;
  logic                out_valid;
  logic                slot;

  // Cyclic scan from ptr for the first valid source; ptr is always in range,
  // so one conditional subtract is enough to wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      scan = 32'(ptr_q) + unsigned'(k);
      if (scan >= NR) scan = scan - NR;
      if (!win_found && bus.req_valid[TAGW'(scan)]) begin
        win_found = 1'b1;
        win_idx   = TAGW'(scan);
      end
    end
  end

  // Grant depends only on registered count/ptr and req_valid, never out_ready.
  assign can_push  = reset && (count_q < 2'd2);
  assign push      = win_found && can_push;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;

  // One-hot ready toward the winning source.
  always_comb begin
    ready = '0;
    if (push) ready[win_idx] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q[0];
  assign bus.out_tag   = tag_q[0];
  assign perf_stalls   = stalls_q;

  // Next-state for pointer, queue, occupancy and stall counter.
  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    tag_d[0]  = tag_q[0];
    tag_d[1]  = tag_q[1];
    data_d[0] = data_q[0];
    data_d[1] = data_q[1];
    stalls_d  = stalls_q;
    slot      = 1'b0;

    if (push) begin
      ptr_d = (win_idx == TAGW'(NR - 1)) ? '0 : win_idx + TAGW'(1);
    end

    // Only shift when a second entry exists; a lone popped head stays put
    // so the outputs hold their last value while empty.
    if (pop && count_q == 2'd2) begin
      tag_d[0]  = tag_q[1];
      data_d[0] = data_q[1];
    end

    // Push lands at the head if the queue is (or becomes) empty, else behind it.
    if (push) begin
      slot = !((count_q == 2'd0) || (count_q == 2'd1 && pop));
      tag_d[slot]  = win_idx;
      data_d[slot] = bus.req_data[win_idx];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (out_valid && !bus.out_ready && stalls_q != 32'hFFFF_FFFF) begin
      stalls_d = stalls_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q     <= '0;
      count_q   <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      stalls_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      tag_q[0]  <= tag_d[0];
      tag_q[1]  <= tag_d[1];
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
      stalls_q  <= stalls_d;
    end
  end

endmodule

// File: tb/tb_vx_tex_req_arb.sv
// Bench for vx_tex_req_arb: directed vector table, a 3-source build check,
// and randomized traffic against a queue-based reference model.
module tb_vx_tex_req_arb;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_4;
  logic rst_3;
  logic [31:0] perf_4;
  logic [31:0] perf_3;

  always #5 clk = ~clk;

  vx_tex_req_arb_if #(.NUM_REQS(4), .DATAW(DW), .TAGW(2)) bus4 ();
  vx_tex_req_arb_if #(.NUM_REQS(3), .DATAW(DW), .TAGW(2)) bus3 ();

  vx_tex_req_arb #(.NUM_REQS(4), .DATAW(DW), .TAGW(2)) dut (
    .clk(clk), .reset(rst_4), .bus(bus4), .perf_stalls(perf_4)
  );

  vx_tex_req_arb #(.NUM_REQS(3), .DATAW(DW), .TAGW(2)) dut3 (
    .clk(clk), .reset(rst_3), .bus(bus3), .perf_stalls(perf_3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] tag;
    int         stall;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [3:0] vl, input logic o,
                             input logic [3:0] rd, input logic ov, input logic [1:0] tg,
                             input int st);
    vec_t x;
    x.rst = r; x.vld = vl; x.ordy = o; x.rdy = rd; x.ov = ov; x.tag = tg; x.stall = st;
    return x;
  endfunction

  vec_t tbl[34];

  // Reference model state: the queue in plain SV queues.
  int          m_ptr;
  int          m_tag[$];
  logic [31:0] m_dat[$];
  int          m_stall;
  int          m_last_tag;
  logic [31:0] m_last_dat;

  logic [3:0]  cur_vld;
  logic [31:0] cur_dat[4];
  logic        cur_rst;
  logic        cur_ordy;

  initial begin
    logic [3:0] exp_rdy;
    logic       exp_ov;
    int         w;
    bit         model_ok;

    rst_4 = 1'b0;
    rst_3 = 1'b0;
    bus4.req_valid = '0;
    bus4.out_ready = 1'b1;
    bus3.req_valid = '0;
    bus3.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus4.req_data[i] = 32'hD000_0000 | 32'(i);
    for (int i = 0; i < 3; i++) bus3.req_data[i] = 32'hE000_0000 | 32'(i);

    // ---------------- directed table ----------------
    tbl[0]  = v(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
    tbl[1]  = v(1, 4'b0100, 1, 4'b0100, 0, 0, 0);
    tbl[2]  = v(1, 4'b0000, 1, 4'b0000, 1, 2, 0);
    tbl[3]  = v(1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    tbl[4]  = v(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
    tbl[5]  = v(1, 4'b1111, 1, 4'b0001, 0, 0, 0);
    tbl[6]  = v(1, 4'b1111, 1, 4'b0010, 1, 0, 0);
    tbl[7]  = v(1, 4'b1111, 1, 4'b0100, 1, 1, 0);
    tbl[8]  = v(1, 4'b1111, 1, 4'b1000, 1, 2, 0);
    tbl[9]  = v(1, 4'b1111, 1, 4'b0001, 1, 3, 0);
    tbl[10] = v(1, 4'b1111, 1, 4'b0010, 1, 0, 0);
    tbl[11] = v(1, 4'b1111, 1, 4'b0100, 1, 1, 0);
    tbl[12] = v(1, 4'b1111, 1, 4'b1000, 1, 2, 0);
    tbl[13] = v(1, 4'b0000, 1, 4'b0000, 1, 3, 0);
    tbl[14] = v(1, 4'b1111, 0, 4'b0001, 0, 0, 0);
    tbl[15] = v(1, 4'b1111, 0, 4'b0010, 1, 0, 0);
    tbl[16] = v(1, 4'b1111, 0, 4'b0000, 1, 0, 1);
    tbl[17] = v(1, 4'b1111, 0, 4'b0000, 1, 0, 2);
    tbl[18] = v(1, 4'b1111, 1, 4'b0000, 1, 0, 3);
    tbl[19] = v(1, 4'b1111, 1, 4'b0100, 1, 1, 3);
    tbl[20] = v(1, 4'b1111, 1, 4'b1000, 1, 2, 3);
    tbl[21] = v(1, 4'b0000, 1, 4'b0000, 1, 3, 3);
    tbl[22] = v(1, 4'b0000, 1, 4'b0000, 0, 0, 3);
    tbl[23] = v(1, 4'b0100, 1, 4'b0100, 0, 0, 3);
    tbl[24] = v(1, 4'b0110, 1, 4'b0010, 1, 2, 3);
    tbl[25] = v(1, 4'b0110, 1, 4'b0100, 1, 1, 3);
    tbl[26] = v(1, 4'b0000, 1, 4'b0000, 1, 2, 3);
    tbl[27] = v(1, 4'b1111, 0, 4'b1000, 0, 0, 3);
    tbl[28] = v(1, 4'b1111, 0, 4'b0001, 1, 3, 3);
    tbl[29] = v(1, 4'b1111, 0, 4'b0000, 1, 3, 4);
    tbl[30] = v(0, 4'b1111, 0, 4'b0000, 1, 3, 5);
    tbl[31] = v(1, 4'b1111, 1, 4'b0001, 0, 0, 0);
    tbl[32] = v(1, 4'b0000, 1, 4'b0000, 1, 0, 0);
    tbl[33] = v(1, 4'b0000, 1, 4'b0000, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 34; r++) begin
      rst_4 = tbl[r].rst;
      bus4.req_valid = tbl[r].vld;
      bus4.out_ready = tbl[r].ordy;
      #2;
      chk($sformatf("tbl%0d_ready", r), 64'(bus4.req_ready), 64'(tbl[r].rdy));
      chk($sformatf("tbl%0d_valid", r), 64'(bus4.out_valid), 64'(tbl[r].ov));
      if (tbl[r].ov) begin
        chk($sformatf("tbl%0d_tag", r), 64'(bus4.out_tag), 64'(tbl[r].tag));
        chk($sformatf("tbl%0d_data", r), 64'(bus4.out_data),
            64'(32'hD000_0000 | 32'(tbl[r].tag)));
      end
      chk($sformatf("tbl%0d_stalls", r), 64'(perf_4), 64'(tbl[r].stall));
      if (r == 0) chk("reset_data", 64'(bus4.out_data), 64'h0);
      @(posedge clk);
      #1;
    end

    // ---------------- 3-source build ----------------
    bus3.req_valid = 3'b111;
    bus3.out_ready = 1'b1;
    rst_3 = 1'b1;
    #2;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("n3_ready%0d", k), 64'(bus3.req_ready), 64'(3'b001 << (k % 3)));
      if (k > 0) begin
        chk($sformatf("n3_valid%0d", k), 64'(bus3.out_valid), 64'h1);
        chk($sformatf("n3_tag%0d", k), 64'(bus3.out_tag), 64'((k - 1) % 3));
        chk($sformatf("n3_data%0d", k), 64'(bus3.out_data),
            64'(32'hE000_0000 | 32'((k - 1) % 3)));
      end
      @(posedge clk);
      #3;
    end
    bus3.req_valid = '0;
    #(-2+2);

    // ---------------- randomized vs reference model ----------------
    model_ok = 0;
    m_ptr = 0; m_stall = 0; m_last_tag = 0; m_last_dat = '0;
    m_tag.delete(); m_dat.delete();
    cur_vld = '0;
    for (int i = 0; i < 4; i++) cur_dat[i] = $urandom;
    cur_ordy = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 1500; n++) begin
      cur_rst = (n == 0) ? 1'b0 : ($urandom_range(0, 79) != 0);
      rst_4 = cur_rst;
      bus4.req_valid = cur_vld;
      bus4.out_ready = cur_ordy;
      for (int i = 0; i < 4; i++) bus4.req_data[i] = cur_dat[i];
      #2;

      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && cur_vld[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      exp_rdy = (cur_rst && w >= 0 && m_tag.size() < 2) ? (4'b0001 << w) : 4'b0000;
      exp_ov  = (m_tag.size() != 0);

      if (model_ok) begin
        chk("rnd_ready", 64'(bus4.req_ready), 64'(exp_rdy));
        chk("rnd_valid", 64'(bus4.out_valid), 64'(exp_ov));
        chk("rnd_tag", 64'(bus4.out_tag), 64'(exp_ov ? m_tag[0] : m_last_tag));
        chk("rnd_data", 64'(bus4.out_data), 64'(exp_ov ? m_dat[0] : m_last_dat));
        chk("rnd_stalls", 64'(perf_4), 64'(m_stall));
      end

      @(posedge clk);
      #1;

      if (!cur_rst) begin
        m_tag.delete(); m_dat.delete();
        m_ptr = 0; m_stall = 0; m_last_tag = 0; m_last_dat = '0;
        model_ok = 1;
      end else begin
        if (exp_ov && !cur_ordy) m_stall++;
        if (exp_ov && cur_ordy) begin
          void'(m_tag.pop_front());
          void'(m_dat.pop_front());
        end
        if (exp_rdy != 0) begin
          m_tag.push_back(w);
          m_dat.push_back(cur_dat[w]);
          m_ptr = (w + 1) % 4;
        end
        if (m_tag.size() != 0) begin
          m_last_tag = m_tag[0];
          m_last_dat = m_dat[0];
        end
      end

      // Sources hold valid and data until accepted.
      for (int i = 0; i < 4; i++) begin
        if (!(cur_vld[i] && !exp_rdy[i])) begin
          cur_vld[i] = ($urandom_range(0, 2) != 0);
          cur_dat[i] = $urandom;
        end
      end
      if (((n / 100) % 3) == 1) cur_ordy = ($urandom_range(0, 3) == 0);
      else                      cur_ordy = ($urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_tex_req_arb.md
# vx_tex_req_arb

Round-robin arbiter that merges texture requests from `NUM_REQS` sources (cores or issue slices) into the single request port of a shared texture unit. Each source presents a packed texture request (uuid, wid, tmask, PC, rd, wb, unit, coords, lod) on a valid/ready handshake. The block selects one request per cycle, buffers it in a 2-entry output queue, and tags it with the winning source index so the response path can route results back. It sits between the per-core texture request interfaces and the texture unit input.

## Interface
- `NUM_REQS`, default 4: number of requesting sources; must be ≥1.
- `DATAW`, default 256: width of the packed request payload.
- `TAGW`, default `$clog2(NUM_REQS)` (minimum 1): width of the source tag.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQS  per-source request valid.
- `req_data`  in  NUM_REQS×DATAW  per-source packed request.
- `req_ready`  out  NUM_REQS  per-source accept; at most one bit high per cycle.
- `out_valid`  out  1  request available to the texture unit.
- `out_data`  out  DATAW  payload at the queue head.
- `out_tag`  out  TAGW  source index of the head entry.
- `out_ready`  in  1  texture unit accepts the head entry.
- `perf_stalls`  out  32  cycles with `out_valid && !out_ready`.

## Operation
- State:
  - Priority pointer `ptr`, of `TAGW` bits, valid range 0..NUM_REQS-1.
  - 2-entry queue of {tag, data} with `count` 0..2.
  - `perf_stalls` counter.
- Arbitration:
  - The winner is the first index i with `req_valid[i]=1`, scanning cyclically from `ptr` (ptr, ptr+1, …, wrapping at NUM_REQS).
  - With no valid request there is no winner.
- Grant:
  - `req_ready[winner] = (count < 2)`; all other ready bits are 0.
  - `req_ready` depends only on registered `count` and `ptr` plus the current `req_valid`. It never depends on `out_ready`.
- Push: when `req_valid[w] && req_ready[w]`, enqueue {w, req_data[w]} and set `ptr <= (w+1) mod NUM_REQS`. With `NUM_REQS` not a power of two, wrap explicitly; never let `ptr` hold an out-of-range value.
- Pop: when `out_valid && out_ready`, dequeue the head.
- Count update:
  - Push only: `count+1`.
  - Pop only: `count-1`.
  - Push and pop together: unchanged.
  - Push is impossible at `count==2`, so overflow cannot occur. No pop occurs at `count==0`.
- Outputs:
  - `out_valid = (count != 0)`.
  - `out_data` and `out_tag` show the head entry. They are undefined-but-stable (hold last value) when the queue is empty.
- `NUM_REQS==1`: `ptr` is constant 0 and `out_tag` is always 0.
- Source contract: a source holding `req_valid` high must keep `req_data` stable until accepted. The arbiter may grant a different source in the meantime; this is not a protocol error.
- `perf_stalls` increments by 1 in each cycle with `out_valid && !out_ready` and saturates at 2^32−1.

## Timing
- Reset (`reset==0` at a clock edge) sets:
  - `ptr=0`, `count=0`
  - `out_valid=0`, `out_data=0`, `out_tag=0`
  - `perf_stalls=0`
  - `req_ready` evaluates to 0 for all sources while held in reset.
- Reset asserted mid-operation discards all queued entries; nothing is emitted afterwards.
- Latency: a request accepted at edge N appears on `out_*` after edge N (visible in cycle N+1), provided it is at the head.
- Throughput:
  - 1 request per cycle sustained when `out_ready` is held high; steady state is `count==1`.
  - After `out_ready` drops, at most 2 further requests are accepted, then all `req_ready` go 0.
  - Acceptance resumes the cycle after the first pop (`count` goes 2 to 1).
- Ordering: output order equals acceptance order; no reordering.
- Fairness: with all sources continuously valid and no backpressure, grants rotate 0,1,…,NUM_REQS−1,0,…

## Test plan
- Reset, then single request: `req_valid=4'b0100`, `req_data[2]=X`, `out_ready=1`. Expected: `req_ready=4'b0100` in cycle 0; `out_valid=1`, `out_tag=2`, `out_data=X` in cycle 1; `out_valid=0` in cycle 2.
- All four sources valid continuously, `out_ready=1`, for 8 cycles. Expected: one acceptance per cycle; `out_tag` sequence is 0,1,2,3,0,1,2,3 starting one cycle after the first grant.
- Backpressure: all sources valid, `out_ready=0`. Expected: exactly 2 acceptances (tags 0,1), then `req_ready=0`; `perf_stalls` increments every cycle with `out_valid=1`. Raise `out_ready`: expected tags 0,1,2,3 in order with no loss or duplication.
- Rotation skip: `ptr=3` after a grant to source 2, with only sources 1 and 2 valid. Expected: source 1 wins (wrap past 3 and 0); the next grant goes to source 2.
- Mid-stream reset: `count=2`, `perf_stalls=5`, assert `reset=0` for one edge. Expected: `out_valid=0`, `perf_stalls=0`, `ptr=0`; the next grant goes to source 0 if valid.
- `NUM_REQS=3` build: sources 0..2 valid continuously. Expected: grants cycle 0,1,2,0; `ptr` never equals 3.
